// File: rtl/pc_gen_pkg.sv
// -----------------------------------------------------------------------------
// pc_gen_pkg
// Shared types and default constants for the fetch-address generator.
//   state_e : fetch FSM state (IDLE / RUN / WAIT)
//   pend_e  : kind of redirect latched while the front end is held
// -----------------------------------------------------------------------------
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PEND_NONE  = 2'd0,
        PEND_JUMP  = 2'd1,
        PEND_FLUSH = 2'd2
    } pend_e;

    localparam int          DEF_XLEN        = 32;
    localparam int          DEF_INSTR_BYTES = 4;
    localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;

endpackage

// File: rtl/pc_gen_ras.sv
// -----------------------------------------------------------------------------
// pc_gen_ras
// Circular return-address stack. A push when full overwrites the oldest entry
// (the write pointer simply wraps and the count saturates). Pop on an empty
// stack is ignored. Push and pop together replace the top entry.
// Ports:
//   clk_i, rst_i   clock / synchronous active-high reset (pointer and count)
//   push_i         push push_data_i
//   pop_i          pop the top entry (ignored when empty)
//   push_data_i    return address to push
//   top_o          current top-of-stack entry
//   empty_o        stack holds no entries
// -----------------------------------------------------------------------------
module pc_gen_ras
    import pc_gen_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] push_data_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] stack_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q;      // next free slot; top lives at ptr_q-1
    logic [PW-1:0]   top_idx;
    logic [CW-1:0]   cnt_q;
    logic            full;
    logic            do_pop;

    assign top_idx = ptr_q - PW'(1);
    assign empty_o = (cnt_q == '0);
    assign full    = (cnt_q == CW'(RAS_DEPTH));
    assign top_o   = stack_q[top_idx];
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (do_pop && push_i) begin
            // replace top in place: pointer and count unchanged
            ptr_q <= ptr_q;
            cnt_q <= cnt_q;
        end else if (push_i) begin
            ptr_q <= ptr_q + PW'(1);
            if (!full) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else if (do_pop) begin
            ptr_q <= top_idx;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Entry storage carries no reset; validity is tracked by cnt_q.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            stack_q[do_pop ? top_idx : ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
// IF-stage fetch-address generator. Advances the PC sequentially and applies
// redirects in priority: EX flush > latched redirect > RAS return > ID jump >
// sequential. Redirects arriving while held are latched so none is lost.
// Optional feature macro: PC_GEN_ALIGN_CHECK_EN adds sticky misalign_o.
// Ports:
//   clk_i, rst_i       clock / synchronous active-high reset
//   start_i            enable; low acts as a stall once running
//   stall_i            hazard stall (hold PC)
//   flush_i, flush_target_i   EX mispredict redirect
//   jump_i,  jump_target_i    ID direct jump / call redirect
//   call_i             ID instruction is a call (qualified by jump_i)
//   ret_i              ID instruction is a return
//   pc_o               current fetch PC
//   valid_o            pc_o is a live fetch address
//   ras_empty_o        return-address stack is empty
//   misalign_o         (PC_GEN_ALIGN_CHECK_EN only) misaligned target loaded
// -----------------------------------------------------------------------------
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN        = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEF_RESET_PC),
    parameter int              INSTR_BYTES = DEF_INSTR_BYTES,
    parameter int              RAS_DEPTH   = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [XLEN-1:0] pc_o,
    output logic            valid_o,
    output logic            ras_empty_o
`ifdef PC_GEN_ALIGN_CHECK_EN
    ,
    output logic            misalign_o
`endif
);

    state_e          state_q, state_d;
    pend_e           pend_kind_q;
    logic [XLEN-1:0] pend_tgt_q;
    logic [XLEN-1:0] pc_q, pc_d, pc_seq;
    logic            hold, active, upd_en, cap_en;
    logic            redirect;
    logic            ras_pop, ras_push;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic            ret_hit;

    assign hold    = stall_i | ~start_i;
    assign active  = (state_q != ST_IDLE);
    assign upd_en  = active & ~hold;
    assign cap_en  = active & hold;
    assign pc_seq  = pc_q + XLEN'(INSTR_BYTES);
    assign ret_hit = ret_i & ~ras_empty;

    // ---- FSM: state register ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_RUN;
            ST_RUN:  if (hold)    state_d = ST_WAIT;
            ST_WAIT: if (!hold)   state_d = ST_RUN;
            default:              state_d = ST_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        valid_o = (state_q == ST_RUN) || (state_q == ST_WAIT);
    end

    // ---- next-PC select ----
    // RAS actions are only taken when a return or jump wins; a flush or a
    // latched redirect suppresses them.
    always_comb begin
        pc_d     = pc_seq;
        redirect = 1'b0;
        ras_pop  = 1'b0;
        ras_push = 1'b0;
        if (flush_i) begin
            pc_d     = flush_target_i;
            redirect = 1'b1;
        end else if (pend_kind_q != PEND_NONE) begin
            pc_d     = pend_tgt_q;
            redirect = 1'b1;
        end else if (ret_hit) begin
            pc_d     = ras_top;
            redirect = 1'b1;
            ras_pop  = upd_en;
            ras_push = upd_en & call_i & jump_i;
        end else if (jump_i) begin
            pc_d     = jump_target_i;
            redirect = 1'b1;
            ras_push = upd_en & call_i;
        end
    end

    // ---- PC and pending-kind registers ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q        <= RESET_PC;
            pend_kind_q <= PEND_NONE;
        end else if (upd_en) begin
            pc_q        <= pc_d;
            pend_kind_q <= PEND_NONE;
        end else if (cap_en) begin
            if (flush_i) begin
                pend_kind_q <= PEND_FLUSH;
            end else if (jump_i && (pend_kind_q != PEND_FLUSH)) begin
                pend_kind_q <= PEND_JUMP;
            end
        end
    end

    // Latched target is data only; pend_kind_q says whether it is meaningful.
    always_ff @(posedge clk_i) begin
        if (cap_en) begin
            if (flush_i) begin
                pend_tgt_q <= flush_target_i;
            end else if (jump_i && (pend_kind_q != PEND_FLUSH)) begin
                pend_tgt_q <= jump_target_i;
            end
        end
    end

    assign pc_o = pc_q;

    pc_gen_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_seq),
        .top_o       (ras_top),
        .empty_o     (ras_empty)
    );

    assign ras_empty_o = ras_empty;

`ifdef PC_GEN_ALIGN_CHECK_EN
    logic misalign_q;
    logic tgt_misaligned;

    assign tgt_misaligned = ((pc_d % XLEN'(INSTR_BYTES)) != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            misalign_q <= 1'b0;
        end else if (upd_en && redirect && tgt_misaligned) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign_o = misalign_q;
`endif

endmodule
